// File: rtl/neuroset_pkg.sv
// rtl/neuroset_pkg.sv - shared widths, arbiter state encoding and index helper
package neuroset_pkg;

    localparam int SIZE_1_DEF           = 11;
    localparam int SIZE_ADDRESS_PIX_DEF = 13;
    localparam int N_REQ_DEF            = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Index of the set bit of a one-hot vector (up to 8 requesters); 0 when empty.
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ram_pix_arbiter_rr_pick.sv
// rtl/ram_pix_arbiter_rr_pick.sv - combinational round-robin one-hot picker
module rr_pick
    import neuroset_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  pick,
    output logic          any
);

    // Walk from ptr upward (wrapping); first unexcluded requester wins.
    always_comb begin
        logic [PW-1:0] idx;
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!any && req[idx] && !excl[idx]) begin
                pick[idx] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_pix_arbiter.sv
// rtl/ram_pix_arbiter.sv - round-robin burst arbiter sharing one pixel RAM port pair
module ram_pix_arbiter
    import neuroset_pkg::*;
#(
    parameter int N_REQ            = N_REQ_DEF,
    parameter int SIZE_1           = SIZE_1_DEF,
    parameter int SIZE_address_pix = SIZE_ADDRESS_PIX_DEF,
    parameter int MAX_BURST        = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req,
    output logic [N_REQ-1:0]                   gnt,
    input  logic [N_REQ-1:0]                   we_i,
    input  logic [N_REQ-1:0]                   re_i,
    input  logic [N_REQ*SIZE_address_pix-1:0]  waddr_i,
    input  logic [N_REQ*SIZE_address_pix-1:0]  raddr_i,
    input  logic [N_REQ*SIZE_1-1:0]            d_i,
    output logic                               we_p,
    output logic                               re_p,
    output logic [SIZE_address_pix-1:0]        write_addressp,
    output logic [SIZE_address_pix-1:0]        read_addressp,
    output logic signed [SIZE_1-1:0]           dp,
    input  logic signed [SIZE_1-1:0]           qp,
    output logic signed [SIZE_1-1:0]           q_o,
    output logic [N_REQ-1:0]                   rvalid,
    output logic                               viol
);

    localparam int A  = SIZE_address_pix;
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    arb_state_t       state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [CW-1:0]    burst_cnt, burst_nxt;
    logic [N_REQ-1:0] pick;
    logic             pick_any;
    logic             owner_req;
    logic [2:0]       win_idx;
    logic [PW-1:0]    win_ptr;

    // Excluding the current grant means "any other requester" while owned
    // and "any requester" while idle (gnt is zero then).
    rr_pick #(.N(N_REQ), .PW(PW)) u_rr_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .excl (gnt),
        .pick (pick),
        .any  (pick_any)
    );

    assign owner_req = |(req & gnt);
    assign win_idx   = onehot_idx(8'(pick));
    assign win_ptr   = (int'(win_idx) + 1 >= N_REQ) ? '0 : PW'(int'(win_idx) + 1);

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_ptr_nxt = rr_ptr;
        burst_nxt  = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt  = OWN;
                    gnt_nxt    = pick;
                    rr_ptr_nxt = win_ptr;
                    burst_nxt  = '0;
                end
            end
            OWN: begin
                if (!owner_req || (burst_cnt == CNT_MAX && pick_any)) begin
                    if (pick_any) begin
                        gnt_nxt    = pick;
                        rr_ptr_nxt = win_ptr;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                    end
                    burst_nxt = '0;
                end else if (burst_cnt != CNT_MAX) begin
                    burst_nxt = burst_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // RAM-side mux straight off the registered grant: no added latency.
    always_comb begin
        we_p           = 1'b0;
        re_p           = 1'b0;
        write_addressp = '0;
        read_addressp  = '0;
        dp             = '0;
        for (int k = 0; k < N_REQ; k++) begin
            we_p           = we_p | (we_i[k] & gnt[k]);
            re_p           = re_p | (re_i[k] & gnt[k]);
            write_addressp = write_addressp | (waddr_i[k*A +: A] & {A{gnt[k]}});
            read_addressp  = read_addressp  | (raddr_i[k*A +: A] & {A{gnt[k]}});
            dp             = dp | (d_i[k*SIZE_1 +: SIZE_1] & {SIZE_1{gnt[k]}});
        end
    end

    assign q_o = qp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            rvalid    <= '0;
            viol      <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_nxt;
            rvalid    <= {N_REQ{re_p}} & gnt;
            viol      <= |((we_i | re_i) & ~gnt);
        end
    end

endmodule
